// File: rtl/adc_freq_meter_pkg.sv
// Shared types and default constants for the ADC frequency meter.
// FSM state encoding and divider iteration count live here.
package adc_freq_meter_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_GATE,
    S_DIV
  } state_t;

  localparam int unsigned DEF_MID         = 8192;
  localparam int unsigned DEF_HYST        = 64;
  localparam int unsigned DEF_GATE_CYCLES = 1048576;
  localparam int unsigned DIV_ITERS       = 32;

endpackage

// File: rtl/serial_udiv.sv
// Restoring unsigned divider, 64-bit numerator by CNT_W divisor, 32-bit quotient.
// The high numerator word must be below the divisor, so only the low 32 bits iterate.
module serial_udiv
  import adc_freq_meter_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [63:0]      num,
  input  logic [CNT_W-1:0] den,
  output logic             done,
  output logic [31:0]      quo
);

  localparam int IW = $clog2(DIV_ITERS + 1);

  logic [CNT_W-1:0] rem;
  logic [31:0]      lo;
  logic [IW-1:0]    cnt;
  logic             busy;
  logic [CNT_W:0]   sh;
  logic [CNT_W:0]   df;
  logic             ge;

  // Trial subtraction of the shifted partial remainder.
  always_comb begin
    sh = {rem, lo[31]};
    df = sh - {1'b0, den};
    ge = (sh >= {1'b0, den});
  end

  // One quotient bit per clock; done pulses with the last bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem  <= '0;
      lo   <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      quo  <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        rem  <= CNT_W'(num[63:32]);
        lo   <= num[31:0];
        quo  <= '0;
        cnt  <= IW'(DIV_ITERS);
        busy <= 1'b1;
      end else if (busy) begin
        rem <= ge ? df[CNT_W-1:0] : sh[CNT_W-1:0];
        quo <= {quo[30:0], ge};
        lo  <= {lo[30:0], 1'b0};
        cnt <= cnt - IW'(1);
        if (cnt == IW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/adc_freq_meter.sv
// Reciprocal frequency meter: Schmitt crossing detector, gated span count, serial divide.
// Define FREQ_METER_CONT_EN for back-to-back measurements without start pulses.
module adc_freq_meter
  import adc_freq_meter_pkg::*;
#(
  parameter int unsigned DATA_W      = 14,
  parameter int unsigned MID         = DEF_MID,
  parameter int unsigned HYST        = DEF_HYST,
  parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       fword,
  output logic [CNT_W-1:0]  periods,
  output logic [CNT_W-1:0]  span
);

  localparam logic [DATA_W-1:0] LO_TH  = DATA_W'(MID - HYST);
  localparam logic [DATA_W-1:0] HI_TH  = DATA_W'(MID + HYST);
  localparam logic [CNT_W-1:0]  G_LAST = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CMAX   = '1;

  state_t           state;
  logic             low_seen;
  logic             xing;
  logic [CNT_W-1:0] tmr;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] spn_cnt;
  logic [CNT_W-1:0] tmr_inc;
  logic [CNT_W-1:0] run_inc;
  logic [CNT_W-1:0] per_inc;
  logic [CNT_W-1:0] per_nxt;
  logic             gate_end;
  logic             fin_err;
  logic             fin_ok;
  logic             div_start;
  logic             div_done;
  logic [31:0]      div_q;
  logic [63:0]      div_num;

  assign xing    = adc_valid && low_seen && (adc_data >= HI_TH);
  assign div_num = {32'(per_cnt), 32'd0};

  // Rising crossing needs a sample below the band before one above it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      low_seen <= 1'b0;
    end else if (adc_valid) begin
      if (adc_data < LO_TH) begin
        low_seen <= 1'b1;
      end else if (xing) begin
        low_seen <= 1'b0;
      end
    end
  end

  // Saturating increments and end-of-measurement conditions.
  always_comb begin
    tmr_inc  = (tmr == CMAX) ? tmr : tmr + CNT_W'(1);
    run_inc  = (run_cnt == CMAX) ? run_cnt : run_cnt + CNT_W'(1);
    per_inc  = (per_cnt == CMAX) ? per_cnt : per_cnt + CNT_W'(1);
    per_nxt  = xing ? per_inc : per_cnt;
    gate_end = (state == S_GATE) && (tmr >= G_LAST);
    fin_err  = ((state == S_ARM) && !xing && (tmr == G_LAST))
             || (gate_end && (per_nxt == '0));
    fin_ok   = (state == S_DIV) && div_done;
  end

  // Measurement FSM; the gate covers GATE_CYCLES clocks starting at the first crossing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      tmr       <= '0;
      run_cnt   <= '0;
      per_cnt   <= '0;
      spn_cnt   <= '0;
      div_start <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      fword     <= '0;
      periods   <= '0;
      span      <= '0;
    end else begin
      done      <= 1'b0;
      div_start <= 1'b0;
      if (fin_err || fin_ok) begin
        done    <= 1'b1;
        err     <= fin_err;
        fword   <= fin_ok ? div_q : '0;
        periods <= fin_ok ? per_cnt : '0;
        span    <= fin_ok ? spn_cnt : '0;
`ifdef FREQ_METER_CONT_EN
        state   <= S_ARM;
        tmr     <= '0;
`else
        state   <= S_IDLE;
        busy    <= 1'b0;
`endif
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start && !done) begin
              state <= S_ARM;
              busy  <= 1'b1;
              tmr   <= '0;
            end
          end
          S_ARM: begin
            if (xing) begin
              state   <= S_GATE;
              tmr     <= CNT_W'(1);
              run_cnt <= '0;
              per_cnt <= '0;
              spn_cnt <= '0;
            end else begin
              tmr <= tmr_inc;
            end
          end
          S_GATE: begin
            tmr     <= tmr_inc;
            run_cnt <= run_inc;
            if (xing) begin
              per_cnt <= per_inc;
              spn_cnt <= run_inc;
            end
            if (gate_end) begin
              state     <= S_DIV;
              div_start <= 1'b1;
            end
          end
          S_DIV: begin
          end
        endcase
      end
    end
  end

  serial_udiv #(
    .CNT_W(CNT_W)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .start(div_start),
    .num  (div_num),
    .den  (spn_cnt),
    .done (div_done),
    .quo  (div_q)
  );

endmodule
